sb_handshake_seq_tx: RTL

//  Parametrised TX-side sideband handshake sequencer for LTSM states (SBINIT, MBINIT.*, etc.).
//  On enable: requests the SB clock pattern, then runs N_STEPS message exchanges in order.

---
 rtl/sb_handshake_seq_tx_pkg.sv | 25 ++
 rtl/sb_handshake_seq_tx_timeout_cnt.sv | 41 ++++
 rtl/sb_handshake_seq_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sb_handshake_seq_tx_pkg.sv
// Shared definitions for the TX-side sideband handshake sequencer:
// sideband message codes used by the LTSM configurations and the FSM state encoding.
package sb_handshake_seq_tx_pkg;

    // Encoded sideband message codes (default 4-bit message width)
    localparam logic [3:0] SB_MSG_NONE          = 4'd0;
    localparam logic [3:0] DONE_REQ             = 4'd1;
    localparam logic [3:0] DONE_RESP            = 4'd2;
    localparam logic [3:0] OUT_OF_RESET         = 4'd3;
    localparam logic [3:0] PARAM_EXCH_REQ       = 4'd4;
    localparam logic [3:0] PARAM_EXCH_RESP      = 4'd5;
    localparam logic [3:0] CAL_DONE_REQ         = 4'd6;
    localparam logic [3:0] CAL_DONE_RESP        = 4'd7;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PATTERN   = 3'd1,
        ST_STEP_SEND = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERROR     = 3'd5
    } sb_tx_state_e;

endpackage

// File: rtl/sb_handshake_seq_tx_timeout_cnt.sv
// Per-state timeout counter. Cleared by the owner on every state change or
// retry; counts while enabled and saturates at TIMEOUT_CYC-1, where it
// reports expiry for as long as it stays enabled.
module sb_timeout_cnt #(
    parameter int unsigned TIMEOUT_W   = 20,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Next count: clear has priority, otherwise saturating increment while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/sb_handshake_seq_tx.sv
// TX-side sideband handshake sequencer. After enable it requests the SB clock
// pattern (with timed retries), then walks N_STEPS request/expect exchanges.
// Each step registers our request code toward the SB encoder and waits until
// both our message has left (valid dropped) and the expected partner message
// has been seen; the partner message may arrive before ours finishes.
module sb_handshake_seq_tx
    import sb_handshake_seq_tx_pkg::*;
#(
    parameter int unsigned SB_MSG_WIDTH = 4,
    parameter int unsigned N_STEPS      = 2,
    parameter int unsigned TIMEOUT_W    = 20,
    parameter int unsigned TIMEOUT_CYC  = 1000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_en,
    input  logic                              i_start_pattern_done,
    input  logic                              i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0]           i_decoded_SB_msg,
    input  logic                              i_falling_edge_busy,
    input  logic                              i_rx_valid,
    input  logic [N_STEPS*SB_MSG_WIDTH-1:0]   i_req_msgs,
    input  logic [N_STEPS*SB_MSG_WIDTH-1:0]   i_exp_msgs,
    output logic [SB_MSG_WIDTH-1:0]           o_encoded_SB_msg_tx,
    output logic                              o_start_pattern_req,
    output logic                              o_valid_tx,
    output logic [$clog2(N_STEPS):0]          o_step_idx,
    output logic                              o_end_tx,
    output logic                              o_error
);

    localparam int unsigned SW = $clog2(N_STEPS) + 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    sb_tx_state_e             state_q, state_d;
    logic [SW-1:0]            step_q, step_d;
    logic [RW-1:0]            retry_q, retry_d;
    logic                     resp_seen_q, resp_seen_d;
    logic [SB_MSG_WIDTH-1:0]  msg_q, msg_d;
    logic                     valid_q, valid_d;
    logic                     start_req_q, start_req_d;
    logic                     end_q, end_d;
    logic                     err_q, err_d;

    logic [SB_MSG_WIDTH-1:0]  req_sel;
    logic [SB_MSG_WIDTH-1:0]  exp_sel;
    logic                     tmr_restart;
    logic                     tmr_clear;
    logic                     tmr_en;
    logic                     tmr_expired;

    // Select the request and expected codes of the current step
    always_comb begin
        req_sel = '0;
        exp_sel = '0;
        for (int k = 0; k < N_STEPS; k++) begin
            if (step_q == SW'(k)) begin
                req_sel = i_req_msgs[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
                exp_sel = i_exp_msgs[k*SB_MSG_WIDTH +: SB_MSG_WIDTH];
            end
        end
    end

    // Next-state and registered-output decode; disable overrides everything
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        resp_seen_d = resp_seen_q;
        msg_d       = msg_q;
        valid_d     = valid_q;
        start_req_d = 1'b0;
        end_d       = end_q;
        err_d       = err_q;
        tmr_restart = 1'b0;

        // Our message is gone once busy falls, unless the RX side still holds the line
        if (valid_q && i_falling_edge_busy && !i_rx_valid) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d     = ST_PATTERN;
                    start_req_d = 1'b1;
                    retry_d     = '0;
                end
            end
            ST_PATTERN: begin
                if (i_start_pattern_done) begin
                    state_d     = ST_STEP_SEND;
                    step_d      = '0;
                    resp_seen_d = 1'b0;
                end else if (tmr_expired) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d     = retry_q + 1'b1;
                        start_req_d = 1'b1;
                        tmr_restart = 1'b1;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            ST_STEP_SEND: begin
                msg_d   = req_sel;
                valid_d = 1'b1;
                state_d = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (i_rx_msg_valid && (i_decoded_SB_msg == exp_sel)) begin
                    resp_seen_d = 1'b1;
                end
                if (resp_seen_q && !valid_q) begin
                    if (step_q < LAST_STEP) begin
                        step_d      = step_q + 1'b1;
                        resp_seen_d = 1'b0;
                        state_d     = ST_STEP_SEND;
                    end else begin
                        state_d = ST_DONE;
                        end_d   = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                end_d = 1'b1;
            end
            ST_ERROR: begin
                err_d   = 1'b1;
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!i_en) begin
            state_d     = ST_IDLE;
            step_d      = '0;
            retry_d     = '0;
            resp_seen_d = 1'b0;
            msg_d       = '0;
            valid_d     = 1'b0;
            start_req_d = 1'b0;
            end_d       = 1'b0;
            err_d       = 1'b0;
        end
    end

    assign tmr_clear = (state_d != state_q) || tmr_restart;
    assign tmr_en    = (state_q == ST_PATTERN) || (state_q == ST_STEP_WAIT);

    sb_timeout_cnt #(
        .TIMEOUT_W   (TIMEOUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (tmr_clear),
        .i_en      (tmr_en),
        .o_expired (tmr_expired)
    );

    // State, step bookkeeping and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            retry_q     <= '0;
            resp_seen_q <= 1'b0;
            msg_q       <= '0;
            valid_q     <= 1'b0;
            start_req_q <= 1'b0;
            end_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            resp_seen_q <= resp_seen_d;
            msg_q       <= msg_d;
            valid_q     <= valid_d;
            start_req_q <= start_req_d;
            end_q       <= end_d;
            err_q       <= err_d;
        end
    end

    assign o_encoded_SB_msg_tx = msg_q;
    assign o_start_pattern_req = start_req_q;
    assign o_valid_tx          = valid_q;
    assign o_step_idx          = step_q;
    assign o_end_tx            = end_q;
    assign o_error             = err_q;

endmodule
